calc_reg_dump: RTL and testbench
================================

Name: calc_reg_dump

Overview:
Downstream consumer of the calculator's register-file read port (`read`/`data`). On a `start` pulse it drives `read` from 0 to N_REGS-1 and captures each `data` word. Each captured word is emitted, tagged with its register index, on a valid/ready output stream. The stream feeds the display/serial stage, giving a full register snapshot without a testbench poking `read` by hand.

Parameters:
- W, 32, data word width (matches calculator W)
- N_REGS, 32, number of registers scanned (1..2^AW)
- AW, 5, address width of `read` / `out_addr`

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  begin a dump; sampled only in IDLE
- read  output  AW  register index driven to calculator read port
- data  input  W  register contents returned by calculator for `read`
- out_data  output  W  captured register value
- out_addr  output  AW  index of `out_data`
- out_valid  output  1  `out_data`/`out_addr` valid
- out_ready  input  1  consumer accepts when high with `out_valid`
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (reset=0, async, any state):
  - state=IDLE; read=0, out_data=0, out_addr=0.
  - out_valid=0, busy=0, done=0; index counter=0.
- Read timing: `read` is registered. `data` is sampled exactly one clock after `read` is updated, which tolerates a 1-cycle read latency in the calculator.
- FSM:
  - IDLE: start=1 → ADDR, read<=0, idx<=0, busy<=1. start=0 → stay.
  - ADDR: wait state so `data` settles for the current `read` → CAPTURE.
  - CAPTURE: out_data<=data, out_addr<=idx, out_valid<=1 → SEND.
  - SEND: hold out_data/out_addr/out_valid stable until out_ready=1.
    - On accept (out_valid&out_ready): out_valid<=0.
    - If idx==N_REGS-1 → DONE.
    - Else idx<=idx+1, read<=idx+1 → ADDR.
  - DONE: done=1 for exactly one cycle, busy<=0 → IDLE.
- Per-word cost: 3 cycles minimum (ADDR, CAPTURE, SEND with out_ready=1).
- Full dump latency: start accepted at edge 0 → done high 3*N_REGS+1 cycles later when out_ready is held high.
- Backpressure: out_ready may stay low indefinitely. While out_valid=1, out_data and out_addr must not change.
- out_valid never rises while out_ready is ignored. No combinational path from out_ready to out_valid.
- start while busy: ignored; no restart, no queueing.
- start in the same cycle as done: ignored (FSM is in DONE, not IDLE).
- Index wrap: idx never exceeds N_REGS-1. With N_REGS=2^AW the counter does not overflow, because termination compares before incrementing.
- Reset mid-dump: immediate return to IDLE with all outputs at reset values. Partial dumps are not resumed.
- `data` is captured as-is; no arithmetic on it.

Optional Feature:
- Macro: CALC_REG_DUMP_SKIP_ZERO_EN.
- Defined:
  - In CAPTURE, if data==0 the word is not emitted: out_valid stays 0.
  - If idx==N_REGS-1 → DONE, else idx/read increment → ADDR.
  - `out_addr` still carries the true register index, so emitted indices are non-contiguous.
  - An all-zero register file produces no output words; done still pulses.
- Not defined: every register is emitted, including zeros; exactly N_REGS words per dump.

Test Plan:
- Reset, then idle: reset low 3 cycles then high, start=0 for 10 cycles → out_valid=0, busy=0, done=0, read=0 throughout.
- Full dump, no backpressure:
  - Stimulus: bench register model reg[i]=i*3+1, out_ready=1, 1-cycle start pulse.
  - Response: 32 words (addr 0..31, data 1,4,...,94) in order.
  - done pulses once, 97 cycles after start; busy=0 afterwards.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles whenever out_valid rises.
  - Response: out_data/out_addr stable during the stall; each word is accepted exactly once; the sequence is identical to the no-backpressure run.
- Start while busy: assert start again at word 10 → ignored; exactly 32 words; a single done pulse.
- Reset mid-dump: drop reset while out_addr=7, out_valid=1 → out_valid=0, busy=0, read=0 asynchronously (before the next clock edge). A new start dumps again from addr 0.
- Skip-zero (macro defined): reg[i]=0 for even i and 0xA5A5_0000+i for odd i → 16 words with addr 1,3,...,31; done pulses once; no words with even addr.

Source files
------------

// File: rtl/calc_reg_dump.sv
// Register-file dump: scans read 0..N_REGS-1 and streams {idx,data} words; 3 cycles/word, stalls in SEND on out_ready low.
// Optional CALC_REG_DUMP_SKIP_ZERO_EN: zero-valued registers are scanned but not emitted.
module calc_reg_dump #(
  parameter int W      = 32,
  parameter int N_REGS = 32,
  parameter int AW     = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] read,
  input  logic [W-1:0]  data,
  output logic [W-1:0]  out_data,
  output logic [AW-1:0] out_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CAPTURE,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(N_REGS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic          out_valid_q, out_valid_d;
  logic          last_idx;
  logic          skip_word;

  assign last_idx = (idx_q == LAST_IDX);

`ifdef CALC_REG_DUMP_SKIP_ZERO_EN
  assign skip_word = (data == '0);
`else
  assign skip_word = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Termination is tested before incrementing, so idx never wraps even when N_REGS == 2**AW.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ADDR;
          idx_d   = '0;
        end
      end
      S_ADDR: state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (skip_word) begin
          if (last_idx) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_ADDR;
          end
        end else begin
          out_data_d  = data;
          out_addr_d  = idx_q;
          out_valid_d = 1'b1;
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (last_idx) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_ADDR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  // read always tracks idx, so the index register doubles as the registered read address.
  assign read      = idx_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_calc_reg_dump.sv
// Bench for calc_reg_dump: register-file model with 1-cycle read latency, stream consumer and word-list reference model.
module tb_calc_reg_dump;
  localparam int W  = 32;
  localparam int N  = 32;
  localparam int AW = 5;
`ifdef CALC_REG_DUMP_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          out_ready;
  logic [AW-1:0] read;
  logic [W-1:0]  data;
  logic [W-1:0]  out_data;
  logic [AW-1:0] out_addr;
  logic          out_valid;
  logic          busy;
  logic          done;

  logic [W-1:0] regs [N];
  int           exp_addr[$];
  logic [W-1:0] exp_data[$];
  int           got_addr[$];
  logic [W-1:0] got_data[$];

  int errors = 0;
  int checks = 0;
  int dc, dn, un, ba, d;
  bit to;

  calc_reg_dump #(.W(W), .N_REGS(N), .AW(AW)) dut (
    .clock(clock), .reset(reset), .start(start), .read(read), .data(data),
    .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Calculator read port: one cycle of read latency.
  always @(posedge clock) data <= regs[read];

  // Reference: registers in index order, zeros dropped only when skip-zero is built in.
  task automatic build_expected();
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < N; i++) begin
      if (!SKIP || regs[i] != 0) begin
        exp_addr.push_back(i);
        exp_data.push_back(regs[i]);
      end
    end
  endtask

  function automatic int first_diff();
    int n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++)
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) return i;
    if (got_addr.size() != exp_addr.size()) return n;
    return -1;
  endfunction

  // Drives one dump and plays the consumer; stall<0 picks a random stall per word.
  task automatic run_dump(input int stall, input int restart_at, output int done_cyc,
                          output int done_cnt, output int unstable, output int busy_after,
                          output bit timeout);
    int stall_cnt = 0;
    bit prev_v = 0;
    bit restarted = 0;
    int h_a = 0;
    logic [W-1:0] h_d = '0;
    got_addr.delete();
    got_data.delete();
    done_cyc = -1; done_cnt = 0; unstable = 0; busy_after = 0; timeout = 1;
    @(negedge clock);
    start = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clock);
      start = 1'b0;
      if (restart_at >= 0 && !restarted && got_addr.size() == restart_at) begin
        start = 1'b1;
        restarted = 1;
      end
      if (done_cyc >= 0 && busy) busy_after++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 5) begin
        timeout = 0;
        break;
      end
      if (out_valid) begin
        if (prev_v && (int'(out_addr) !== h_a || out_data !== h_d)) unstable++;
        if (!prev_v) begin
          h_a = int'(out_addr);
          h_d = out_data;
          stall_cnt = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
        end
        if (stall_cnt > 0) begin
          out_ready = 1'b0;
          stall_cnt--;
        end else begin
          out_ready = 1'b1;
          got_addr.push_back(int'(out_addr));
          got_data.push_back(out_data);
        end
      end else begin
        out_ready = 1'b1;
      end
      prev_v = out_valid;
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    start = 1'b0; out_ready = 1'b1; reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, done, read, out_addr, out_data} !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b done=%b read=%0d addr=%0d data=%h, want all 0",
               out_valid, busy, done, read, out_addr, out_data);
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if ({out_valid, busy, done, read} !== '0) begin
        errors++;
        $display("FAIL idle_cycle%0d: valid=%b busy=%b done=%b read=%0d, want 0 0 0 0",
                 i, out_valid, busy, done, read);
      end
    end
  endtask

  task automatic test_full_dump();
    for (int i = 0; i < N; i++) regs[i] = W'(i * 3 + 1);
    build_expected();
    run_dump(0, -1, dc, dn, un, ba, to);
    d = first_diff();
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL full_timeout: no done within budget"); end
    checks++;
    if (d !== -1) begin
      errors++;
      $display("FAIL full_seq word %0d: got %0d words, want %0d", d, got_addr.size(), exp_addr.size());
    end
    checks++;
    if (dc !== 3 * N + 1) begin errors++; $display("FAIL full_latency: got %0d cycles, want %0d", dc, 3 * N + 1); end
    checks++;
    if (dn !== 1) begin errors++; $display("FAIL full_done_pulses: got %0d, want 1", dn); end
    checks++;
    if (ba !== 0) begin errors++; $display("FAIL full_busy_after: busy high %0d cycles after done, want 0", ba); end
  endtask

  task automatic test_backpressure();
    build_expected();
    run_dump(5, -1, dc, dn, un, ba, to);
    d = first_diff();
    checks++;
    if (d !== -1) begin
      errors++;
      $display("FAIL bp_seq word %0d: got %0d words, want %0d", d, got_addr.size(), exp_addr.size());
    end
    checks++;
    if (un !== 0) begin errors++; $display("FAIL bp_stable: %0d changes while stalled, want 0", un); end
    checks++;
    if (dc !== 3 * N + 1 + 5 * N) begin errors++; $display("FAIL bp_latency: got %0d, want %0d", dc, 8 * N + 1); end
    checks++;
    if (dn !== 1 || to !== 1'b0) begin errors++; $display("FAIL bp_done: pulses=%0d timeout=%b, want 1 0", dn, to); end
  endtask

  task automatic test_start_while_busy();
    build_expected();
    run_dump(0, 10, dc, dn, un, ba, to);
    d = first_diff();
    checks++;
    if (d !== -1) begin
      errors++;
      $display("FAIL restart_seq word %0d: got %0d words, want %0d", d, got_addr.size(), exp_addr.size());
    end
    checks++;
    if (dn !== 1 || dc !== 3 * N + 1) begin
      errors++;
      $display("FAIL restart_done: pulses=%0d at %0d, want 1 at %0d", dn, dc, 3 * N + 1);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    @(negedge clock);
    start = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (out_valid && out_addr == AW'(7)) found = 1;
      else out_ready = out_valid ? 1'b1 : 1'b0;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL midreset_reach: addr 7 never offered"); end
    reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, done, read, out_addr} !== '0) begin
      errors++;
      $display("FAIL midreset_async: valid=%b busy=%b done=%b read=%0d addr=%0d, want all 0",
               out_valid, busy, done, read, out_addr);
    end
    @(negedge clock);
    reset = 1'b1; out_ready = 1'b1;
    build_expected();
    run_dump(0, -1, dc, dn, un, ba, to);
    d = first_diff();
    checks++;
    if (d !== -1 || dn !== 1) begin
      errors++;
      $display("FAIL midreset_redump: diff at %0d, %0d words, %0d done pulses, want %0d words 1 pulse",
               d, got_addr.size(), dn, exp_addr.size());
    end
  endtask

  task automatic test_skip_zero();
    for (int i = 0; i < N; i++) regs[i] = (i % 2 == 0) ? '0 : (32'hA5A5_0000 + W'(i));
    build_expected();
    run_dump(0, -1, dc, dn, un, ba, to);
    d = first_diff();
    checks++;
    if (d !== -1) begin
      errors++;
      $display("FAIL skip_seq word %0d: got %0d words, want %0d", d, got_addr.size(), exp_addr.size());
    end
    checks++;
    if (dn !== 1 || to !== 1'b0) begin errors++; $display("FAIL skip_done: pulses=%0d timeout=%b, want 1 0", dn, to); end
    for (int i = 0; i < N; i++) regs[i] = '0;
    build_expected();
    run_dump(0, -1, dc, dn, un, ba, to);
    checks++;
    if (got_addr.size() !== exp_addr.size() || dn !== 1) begin
      errors++;
      $display("FAIL allzero: got %0d words %0d pulses, want %0d words 1 pulse", got_addr.size(), dn, exp_addr.size());
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) regs[i] = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
      build_expected();
      run_dump(-1, -1, dc, dn, un, ba, to);
      d = first_diff();
      checks++;
      if (d !== -1 || un !== 0) begin
        errors++;
        $display("FAIL rand%0d_seq: diff at %0d, %0d words (want %0d), %0d unstable", r, d, got_addr.size(),
                 exp_addr.size(), un);
      end
      checks++;
      if (dn !== 1 || to !== 1'b0) begin errors++; $display("FAIL rand%0d_done: pulses=%0d timeout=%b, want 1 0", r, dn, to); end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) regs[i] = '0;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid();
    test_skip_zero();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
